draw_seq: RTL and testbench
===========================

Name: draw_seq

Overview:
- Sequencer and pixel-write mux sitting directly downstream of the screen-clear engine and the line-drawing engine.
- Holds each engine in reset until it is needed, then releases it and forwards its pixel stream to the VGA framebuffer write port.
- Accepts one-shot clear requests and buffered line-segment commands; only one engine runs at a time.

Parameters:
H_RES, 640, visible columns; fb writes with x >= H_RES are suppressed
V_RES, 480, visible rows; fb writes with y >= V_RES are suppressed
WDOG_CYCLES, 400000, run-phase cycle limit (used only with DRAW_WDOG_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clear_req  in  1  single-cycle pulse requesting a full-screen clear to black
seg_valid  in  1  segment command valid
seg_ready  out  1  segment buffer empty (= !buf_full)
seg_x0, seg_x1  in  10  segment endpoint x
seg_y0, seg_y1  in  9  segment endpoint y
seg_color  in  1  segment pixel colour
clr_reset  out  1  reset to clear engine; 1 = held
clr_x  in  10  clear engine x
clr_y  in  9  clear engine y
clr_done  in  1  clear engine finished
ln_reset  out  1  reset to line engine; 1 = held
ln_x0, ln_x1  out  10  registered endpoints to line engine
ln_y0, ln_y1  out  9  registered endpoints to line engine
ln_x  in  10  line engine pixel x
ln_y  in  9  line engine pixel y
ln_done  in  1  line engine finished
fb_x  out  10  framebuffer x
fb_y  out  9  framebuffer y
fb_color  out  1  framebuffer pixel
fb_we  out  1  framebuffer write enable
busy  out  1  state != IDLE or work pending
err  out  1  sticky watchdog flag

Behaviour:
Reset (async, active-high):
- state=IDLE; clr_reset=1, ln_reset=1.
- fb_we=0, fb_x=0, fb_y=0, fb_color=0.
- ln_* endpoints=0; buf_full=0 so seg_ready=1; clr_pend=0; busy=0; err=0.
- Asserting reset mid-operation aborts immediately; buffered segment and pending clear are discarded.

Input capture:
- seg_valid & seg_ready at an edge loads the one-deep buffer and sets buf_full.
- Coordinates are clamped on load: x > H_RES-1 becomes H_RES-1; y > V_RES-1 becomes V_RES-1.
- clear_req in any state sets clr_pend. Repeated requests before service merge into one.

FSM states: IDLE, CLR_ARM, CLR_RUN, LN_ARM, LN_RUN.
- IDLE:
  - If clr_pend, go to CLR_ARM. Clear has priority over a buffered segment.
  - Else if buf_full: copy the buffer into ln_* and ln_color, clear buf_full, go to LN_ARM.
- CLR_ARM: lasts 1 cycle; clr_reset=1; clr_pend cleared. Next state is CLR_RUN.
- CLR_RUN: clr_reset=0. When clr_done=1, go to IDLE.
- LN_ARM: lasts 1 cycle; ln_reset=1. Next state is LN_RUN.
- LN_RUN: ln_reset=0. When ln_done=1, go to IDLE.
- Outside its RUN state, each engine's reset output is 1.

Write mux (combinational from state and engine outputs):
- In CLR_RUN: fb_x=clr_x, fb_y=clr_y, fb_color=0, fb_we=!clr_done.
- In LN_RUN: fb_x=ln_x, fb_y=ln_y, fb_color=ln_color, fb_we=!ln_done.
- In all other states, fb_we=0.
- fb_we is additionally forced to 0 whenever fb_x >= H_RES or fb_y >= V_RES. The clear engine overshoots to x=H_RES and y=V_RES, and those writes must never reach the framebuffer.

Timing and status:
- Latency: clear_req sampled at edge n (IDLE) -> CLR_ARM during cycle n+1 -> clr_reset falls and the first write occurs in cycle n+2.
- busy = (state != IDLE) | clr_pend | buf_full.
- A new segment may be accepted during any run phase (buffer refill). The next segment therefore starts 3 cycles after the previous ln_done: IDLE, LN_ARM, LN_RUN.

Optional Feature:
DRAW_WDOG_EN
- Defined: a counter clears on entry to CLR_RUN or LN_RUN and increments each run cycle. On reaching WDOG_CYCLES, the block forces state=IDLE, sets sticky err=1 (cleared only by reset), and drives the engine reset output high.
- Undefined: no counter; err tied to 0; run phases wait indefinitely for done.

Test Plan:
- H_RES=8, V_RES=6, stub clear engine modelling a column-scanning clear. Pulse clear_req -> exactly 48 fb_we pulses with fb_color=0 covering (0..7,0..5); none at x=8 or y=6; busy falls 1 cycle after clr_done.
- Segment (1,1)->(5,3), color 1, with a stub line engine emitting 5 pixels then done -> ln_reset low for 6 cycles; 5 writes with fb_color=1; seg_ready returns high the cycle after the IDLE load.
- clear_req and seg_valid presented in the same IDLE cycle -> the clear runs fully first, then the line; the segment is held (seg_ready=0) until it is loaded into ln_*.
- Segment (700,500)->(2,2) -> ln_x0=639, ln_y0=479 at default parameters.
- Async reset asserted mid-CLR_RUN with a segment buffered -> same cycle fb_we=0, clr_reset=1, ln_reset=1, busy=0 and seg_ready=1; after release the block stays idle.
- With DRAW_WDOG_EN and WDOG_CYCLES=20, a clr_done stuck at 0 -> err=1 at run cycle 20; state returns to IDLE; a following segment still executes.

Source files
------------

// File: rtl/draw_seq.sv
// -----------------------------------------------------------------------------
// draw_seq -- drawing sequencer and framebuffer write mux
//
// Sits between the screen-clear engine, the line-drawing engine and the VGA
// framebuffer write port. Each engine is held in reset until its turn, then
// released, and its pixel stream is forwarded to the framebuffer. Only one
// engine runs at a time; a pending clear wins over a buffered segment.
//
// Optional feature (compile-time macro): DRAW_WDOG_EN
//   defined   : run phases are bounded by WDOG_CYCLES; on expiry the block
//               returns to IDLE and raises the sticky err flag.
//   undefined : no watchdog, err is tied low, run phases wait for done.
//
// Parameters
//   H_RES, V_RES  visible area; writes at x >= H_RES or y >= V_RES are dropped
//   WDOG_CYCLES   run-phase cycle limit (watchdog build only)
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   clear_req                  one-cycle clear request (merged while pending)
//   seg_valid/seg_ready        segment command handshake (one-deep buffer)
//   seg_x0/x1, seg_y0/y1       segment endpoints (clamped into visible area)
//   seg_color                  segment pixel colour
//   clr_reset, clr_x/y, clr_done   clear engine control / pixel stream
//   ln_reset, ln_x0/x1/y0/y1       line engine control / registered endpoints
//   ln_x/y, ln_done                line engine pixel stream
//   fb_x, fb_y, fb_color, fb_we    framebuffer write port
//   busy                       sequencer active or work pending
//   err                        sticky watchdog expiry flag
// -----------------------------------------------------------------------------
module draw_seq #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int WDOG_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    input  logic       seg_valid,
    output logic       seg_ready,
    input  logic [9:0] seg_x0,
    input  logic [9:0] seg_x1,
    input  logic [8:0] seg_y0,
    input  logic [8:0] seg_y1,
    input  logic       seg_color,
    output logic       clr_reset,
    input  logic [9:0] clr_x,
    input  logic [8:0] clr_y,
    input  logic       clr_done,
    output logic       ln_reset,
    output logic [9:0] ln_x0,
    output logic [9:0] ln_x1,
    output logic [8:0] ln_y0,
    output logic [8:0] ln_y1,
    input  logic [9:0] ln_x,
    input  logic [8:0] ln_y,
    input  logic       ln_done,
    output logic [9:0] fb_x,
    output logic [8:0] fb_y,
    output logic       fb_color,
    output logic       fb_we,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLR_ARM = 3'd1,
        CLR_RUN = 3'd2,
        LN_ARM  = 3'd3,
        LN_RUN  = 3'd4
    } state_t;

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);
    localparam logic [9:0] X_LIM = 10'(H_RES);
    localparam logic [8:0] Y_LIM = 9'(V_RES);

    state_t     state;
    state_t     state_next;
    logic       ln_load;
    logic       wdog_trip;

    logic       buf_full;
    logic [9:0] buf_x0;
    logic [9:0] buf_x1;
    logic [8:0] buf_y0;
    logic [8:0] buf_y1;
    logic       buf_color;
    logic       ln_color;
    logic       clr_pend;
    logic       fb_we_raw;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic. clear_req is looked at directly in IDLE so that a
    // request lands in CLR_ARM on the very next cycle.
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        ln_load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_pend || clear_req) begin
                    state_next = CLR_ARM;
                end else if (buf_full) begin
                    state_next = LN_ARM;
                    ln_load    = 1'b1;
                end
            end
            CLR_ARM: state_next = CLR_RUN;
            CLR_RUN: if (clr_done) state_next = IDLE;
            LN_ARM:  state_next = LN_RUN;
            LN_RUN:  if (ln_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (wdog_trip) state_next = IDLE;
    end

    // Engines are released only during their own run phase.
    assign clr_reset = (state != CLR_RUN);
    assign ln_reset  = (state != LN_RUN);
    assign seg_ready = !buf_full;
    assign busy      = (state != IDLE) || clr_pend || buf_full;

    // ------------------------------------------------------------------
    // Segment buffer, line endpoints and clear request flag.
    // ------------------------------------------------------------------
    // NOTE: these are a handful of flops, not a RAM, so they are reset;
    // a reset must discard any buffered segment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full  <= 1'b0;
            buf_x0    <= '0;
            buf_x1    <= '0;
            buf_y0    <= '0;
            buf_y1    <= '0;
            buf_color <= 1'b0;
            ln_x0     <= '0;
            ln_x1     <= '0;
            ln_y0     <= '0;
            ln_y1     <= '0;
            ln_color  <= 1'b0;
            clr_pend  <= 1'b0;
        end else begin
            if (clear_req)             clr_pend <= 1'b1;
            else if (state == CLR_ARM) clr_pend <= 1'b0;

            // A load always empties the buffer, so it never collides with
            // a capture (capture needs an empty buffer).
            if (ln_load) begin
                ln_x0    <= buf_x0;
                ln_x1    <= buf_x1;
                ln_y0    <= buf_y0;
                ln_y1    <= buf_y1;
                ln_color <= buf_color;
                buf_full <= 1'b0;
            end else if (seg_valid && !buf_full) begin
                buf_x0    <= (seg_x0 > X_MAX) ? X_MAX : seg_x0;
                buf_x1    <= (seg_x1 > X_MAX) ? X_MAX : seg_x1;
                buf_y0    <= (seg_y0 > Y_MAX) ? Y_MAX : seg_y0;
                buf_y1    <= (seg_y1 > Y_MAX) ? Y_MAX : seg_y1;
                buf_color <= seg_color;
                buf_full  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framebuffer write mux. The clear engine overshoots to x=H_RES and
    // y=V_RES, so anything outside the visible area is dropped here.
    // ------------------------------------------------------------------
    always_comb begin
        fb_x      = '0;
        fb_y      = '0;
        fb_color  = 1'b0;
        fb_we_raw = 1'b0;
        unique case (state)
            CLR_RUN: begin
                fb_x      = clr_x;
                fb_y      = clr_y;
                fb_we_raw = !clr_done;
            end
            LN_RUN: begin
                fb_x      = ln_x;
                fb_y      = ln_y;
                fb_color  = ln_color;
                fb_we_raw = !ln_done;
            end
            default: ;
        endcase
    end

    assign fb_we = fb_we_raw && (fb_x < X_LIM) && (fb_y < Y_LIM);

    // ------------------------------------------------------------------
    // Optional run-phase watchdog
    // ------------------------------------------------------------------
`ifdef DRAW_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              run_phase;
    logic              run_done;

    assign run_phase = (state == CLR_RUN) || (state == LN_RUN);
    assign run_done  = (state == CLR_RUN) ? clr_done : ln_done;
    // The count holds the number of completed run cycles; the trip fires in
    // the cycle that would complete the WDOG_CYCLES-th one, unless done
    // arrives in that same cycle.
    assign wdog_trip = run_phase && !run_done &&
                       (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == CLR_ARM || state == LN_ARM) wdog_cnt <= '0;
            else if (run_phase)                      wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_trip) err <= 1'b1;
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = (WDOG_CYCLES > 0);
    assign wdog_trip   = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_draw_seq.sv
// -----------------------------------------------------------------------------
// tb_draw_seq -- directed testbench for draw_seq
//
// Main DUT runs with H_RES=8, V_RES=6, WDOG_CYCLES=20 against stub clear and
// line engines. A second instance at default parameters checks clamping.
// -----------------------------------------------------------------------------
module tb_draw_seq;

    localparam int HR = 8;
    localparam int VR = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear_req;
    logic       seg_valid;
    logic       seg_valid2;
    logic [9:0] seg_x0, seg_x1;
    logic [8:0] seg_y0, seg_y1;
    logic       seg_color;
    logic       clr_stuck;

    logic       seg_ready, clr_reset, ln_reset, fb_color, fb_we, busy, err;
    logic [9:0] ln_x0, ln_x1, fb_x, clr_x, ln_x;
    logic [8:0] ln_y0, ln_y1, fb_y, clr_y, ln_y;
    logic       clr_done, ln_done;

    logic       d_seg_ready, d_clr_reset, d_ln_reset, d_fb_color, d_fb_we, d_busy, d_err;
    logic [9:0] d_ln_x0, d_ln_x1, d_fb_x;
    logic [8:0] d_ln_y0, d_ln_y1, d_fb_y;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    draw_seq #(.H_RES(HR), .V_RES(VR), .WDOG_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .seg_valid(seg_valid), .seg_ready(seg_ready),
        .seg_x0(seg_x0), .seg_x1(seg_x1), .seg_y0(seg_y0), .seg_y1(seg_y1),
        .seg_color(seg_color),
        .clr_reset(clr_reset), .clr_x(clr_x), .clr_y(clr_y), .clr_done(clr_done),
        .ln_reset(ln_reset), .ln_x0(ln_x0), .ln_x1(ln_x1), .ln_y0(ln_y0), .ln_y1(ln_y1),
        .ln_x(ln_x), .ln_y(ln_y), .ln_done(ln_done),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_we(fb_we),
        .busy(busy), .err(err)
    );

    draw_seq dut_def (
        .clk(clk), .reset(reset), .clear_req(1'b0),
        .seg_valid(seg_valid2), .seg_ready(d_seg_ready),
        .seg_x0(seg_x0), .seg_x1(seg_x1), .seg_y0(seg_y0), .seg_y1(seg_y1),
        .seg_color(seg_color),
        .clr_reset(d_clr_reset), .clr_x(10'd0), .clr_y(9'd0), .clr_done(1'b0),
        .ln_reset(d_ln_reset), .ln_x0(d_ln_x0), .ln_x1(d_ln_x1),
        .ln_y0(d_ln_y0), .ln_y1(d_ln_y1),
        .ln_x(10'd0), .ln_y(9'd0), .ln_done(1'b0),
        .fb_x(d_fb_x), .fb_y(d_fb_y), .fb_color(d_fb_color), .fb_we(d_fb_we),
        .busy(d_busy), .err(d_err)
    );

    // Stub clear engine: scans each column y=0..VR, then steps x, ending at
    // the overshoot corner (HR,VR) where it reports done.
    logic [9:0] cx;
    logic [8:0] cy;
    always @(posedge clk) begin
        if (clr_reset) begin
            cx <= '0;
            cy <= '0;
        end else if (!(cx == 10'(HR) && cy == 9'(VR))) begin
            if (cy == 9'(VR)) begin
                cy <= '0;
                cx <= cx + 1'b1;
            end else begin
                cy <= cy + 1'b1;
            end
        end
    end
    assign clr_x    = cx;
    assign clr_y    = cy;
    assign clr_done = (cx == 10'(HR)) && (cy == 9'(VR)) && !clr_stuck;

    // Stub line engine: five pixels along x starting at (ln_x0, ln_y0), then done.
    logic [2:0] lcnt;
    always @(posedge clk) begin
        if (ln_reset)          lcnt <= '0;
        else if (lcnt != 3'd5) lcnt <= lcnt + 1'b1;
    end
    assign ln_x    = ln_x0 + 10'(lcnt);
    assign ln_y    = ln_y0;
    assign ln_done = (lcnt == 3'd5);

    // Write monitor, sampled on the falling edge.
    int         wr_cnt, wr_col1, wr_oob, ln_low, overlap;
    logic [9:0] last_x;
    logic [8:0] last_y;
    bit         cov [HR][VR];

    always @(negedge clk) begin
        if (fb_we) begin
            wr_cnt++;
            if (fb_color) wr_col1++;
            if (fb_x >= 10'(HR) || fb_y >= 9'(VR)) wr_oob++;
            else cov[fb_x][fb_y] = 1'b1;
            last_x = fb_x;
            last_y = fb_y;
        end
        if (!ln_reset) ln_low++;
        if (!ln_reset && !clr_reset) overlap++;
    end

    task automatic clear_stats();
        wr_cnt  = 0;
        wr_col1 = 0;
        wr_oob  = 0;
        ln_low  = 0;
        overlap = 0;
        for (int x = 0; x < HR; x++)
            for (int y = 0; y < VR; y++)
                cov[x][y] = 1'b0;
    endtask

    function automatic int cov_count();
        int n = 0;
        for (int x = 0; x < HR; x++)
            for (int y = 0; y < VR; y++)
                if (cov[x][y]) n++;
        return n;
    endfunction

    // Inputs change and outputs are read 1 ns after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clr_done(input string tag);
        int n = 0;
        while (clr_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(tag, 32'(clr_done), 32'd1);
    endtask

    task automatic wait_ln_done(input string tag);
        int n = 0;
        while (ln_done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(ln_done), 32'd1);
    endtask

    task automatic set_seg(input int x0, input int y0, input int x1, input int y1, input logic c);
        seg_x0    = 10'(x0);
        seg_y0    = 9'(y0);
        seg_x1    = 10'(x1);
        seg_y1    = 9'(y1);
        seg_color = c;
    endtask

    initial begin
        reset      = 1'b1;
        clear_req  = 1'b0;
        seg_valid  = 1'b0;
        seg_valid2 = 1'b0;
        clr_stuck  = 1'b0;
        set_seg(0, 0, 0, 0, 1'b0);
        clear_stats();

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_clr_reset", 32'(clr_reset), 32'd1);
        check("rst_ln_reset",  32'(ln_reset),  32'd1);
        check("rst_fb_we",     32'(fb_we),     32'd0);
        check("rst_fb_x",      32'(fb_x),      32'd0);
        check("rst_seg_ready", 32'(seg_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_ln_x0",     32'(ln_x0),     32'd0);
        reset = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // ---------------- full-screen clear ----------------
        clear_stats();
        clear_req = 1'b1;
        step();                                     // CLR_ARM
        clear_req = 1'b0;
        check("arm_clr_reset", 32'(clr_reset), 32'd1);
        check("arm_busy",      32'(busy),      32'd1);
        step();                                     // first CLR_RUN cycle
        check("run_clr_reset", 32'(clr_reset), 32'd0);
        check("run_first_we",  32'(fb_we),     32'd1);
        wait_clr_done("clr_done_seen");
        check("done_cycle_busy", 32'(busy),  32'd1);
        check("done_cycle_we",   32'(fb_we), 32'd0);
        step();
        check("clr_busy_fall",  32'(busy),        32'd0);
        check("clr_reheld",     32'(clr_reset),   32'd1);
        check("clr_writes",     32'(wr_cnt),      32'd48);
        check("clr_oob",        32'(wr_oob),      32'd0);
        check("clr_color",      32'(wr_col1),     32'd0);
        check("clr_cover",      32'(cov_count()), 32'd48);

        // ---------------- single segment ----------------
        clear_stats();
        set_seg(1, 1, 5, 3, 1'b1);
        seg_valid = 1'b1;
        step();                                     // captured in buffer
        seg_valid = 1'b0;
        check("seg_buf_ready", 32'(seg_ready), 32'd0);
        check("seg_buf_busy",  32'(busy),      32'd1);
        step();                                     // LN_ARM after IDLE load
        check("seg_ready_back", 32'(seg_ready), 32'd1);
        check("seg_arm_lnrst",  32'(ln_reset),  32'd1);
        check("seg_ln_x0",      32'(ln_x0),     32'd1);
        check("seg_ln_y0",      32'(ln_y0),     32'd1);
        check("seg_ln_x1",      32'(ln_x1),     32'd5);
        check("seg_ln_y1",      32'(ln_y1),     32'd3);
        wait_ln_done("ln_done_seen");
        step();
        check("seg_ln_low",  32'(ln_low),  32'd6);
        check("seg_writes",  32'(wr_cnt),  32'd5);
        check("seg_color",   32'(wr_col1), 32'd5);
        check("seg_last_x",  32'(last_x),  32'd5);
        check("seg_last_y",  32'(last_y),  32'd1);
        check("seg_busy",    32'(busy),    32'd0);

        // ---------------- clear and segment together ----------------
        clear_stats();
        set_seg(2, 3, 4, 4, 1'b1);
        clear_req = 1'b1;
        seg_valid = 1'b1;
        step();                                     // CLR_ARM, segment buffered
        clear_req = 1'b0;
        seg_valid = 1'b0;
        check("both_clr_first", 32'(clr_reset), 32'd1);
        check("both_ln_held",   32'(ln_reset),  32'd1);
        check("both_held",      32'(seg_ready), 32'd0);
        wait_clr_done("both_clr_done");
        check("both_held_run",  32'(seg_ready), 32'd0);
        step();                                     // IDLE with buffer full
        check("both_held_idle", 32'(seg_ready), 32'd0);
        check("both_clr_count", 32'(wr_cnt),    32'd48);
        step();                                     // LN_ARM
        check("both_released",  32'(seg_ready), 32'd1);
        check("both_ln_x0",     32'(ln_x0),     32'd2);
        check("both_ln_y0",     32'(ln_y0),     32'd3);
        wait_ln_done("both_ln_done");
        step();
        check("both_writes",  32'(wr_cnt),  32'd53);
        check("both_col1",    32'(wr_col1), 32'd5);
        check("both_overlap", 32'(overlap), 32'd0);
        check("both_busy",    32'(busy),    32'd0);

        // ---------------- coordinate clamping ----------------
        clear_stats();
        set_seg(700, 500, 2, 2, 1'b1);
        seg_valid  = 1'b1;
        seg_valid2 = 1'b1;
        step();
        seg_valid  = 1'b0;
        seg_valid2 = 1'b0;
        step();
        check("clamp_def_x0", 32'(d_ln_x0), 32'd639);
        check("clamp_def_y0", 32'(d_ln_y0), 32'd479);
        check("clamp_def_x1", 32'(d_ln_x1), 32'd2);
        check("clamp_sml_x0", 32'(ln_x0),   32'd7);
        check("clamp_sml_y0", 32'(ln_y0),   32'd5);
        wait_ln_done("clamp_ln_done");
        step();
        // Stub walks x=7..11 at y=5; only x=7 is visible.
        check("clamp_writes", 32'(wr_cnt), 32'd1);

        // ---------------- async reset mid clear ----------------
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();                                     // CLR_RUN
        set_seg(3, 3, 6, 3, 1'b1);
        seg_valid = 1'b1;
        step();
        seg_valid = 1'b0;
        check("abort_pre_we",    32'(fb_we),     32'd1);
        check("abort_pre_ready", 32'(seg_ready), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("abort_we",        32'(fb_we),     32'd0);
        check("abort_clr_reset", 32'(clr_reset), 32'd1);
        check("abort_ln_reset",  32'(ln_reset),  32'd1);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_ready",     32'(seg_ready), 32'd1);
        step();
        reset = 1'b0;
        clear_stats();
        for (int i = 0; i < 10; i++) step();
        check("abort_idle_busy",  32'(busy),    32'd0);
        check("abort_idle_wr",    32'(wr_cnt),  32'd0);
        check("abort_idle_lnlow", 32'(ln_low),  32'd0);

`ifdef DRAW_WDOG_EN
        // ---------------- watchdog ----------------
        clr_stuck = 1'b1;
        clear_req = 1'b1;
        step();                                     // CLR_ARM
        clear_req = 1'b0;
        step();                                     // run cycle 1
        for (int i = 1; i < 20; i++) step();        // run cycle 20
        check("wdog_run20_err", 32'(err),       32'd0);
        check("wdog_run20_rst", 32'(clr_reset), 32'd0);
        step();
        check("wdog_err",       32'(err),       32'd1);
        check("wdog_clr_reset", 32'(clr_reset), 32'd1);
        check("wdog_busy",      32'(busy),      32'd0);
        clr_stuck = 1'b0;
        clear_stats();
        set_seg(0, 2, 4, 2, 1'b1);
        seg_valid = 1'b1;
        step();
        seg_valid = 1'b0;
        step();
        wait_ln_done("wdog_ln_done");
        step();
        check("wdog_seg_writes", 32'(wr_cnt), 32'd5);
        check("wdog_err_sticky", 32'(err),    32'd1);
`else
        check("no_wdog_err", 32'(err),   32'd0);
        check("def_err",     32'(d_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
